hex_scan_display: RTL and testbench

Parametrised multi-digit hexadecimal seven-segment driver that time-multiplexes DIGITS common-anode digits from a single segment bus. It captures a packed hex value on a load strobe and scans digits with a programmable prescaler. It adds the following:

- decoding for all 16 hex values;
- per-digit blanking;
- leading-zero suppression;
- inter-digit dead time;
- optional tear-free loading at frame boundaries.

It sits between board-level control logic and the 7-seg/anode pins.

---
 rtl/hex_scan_display.sv | 176 +++++++++++++++++
 tb/tb_hex_scan_display.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_display.sv
// hex_scan_display: time-multiplexed hexadecimal seven-segment driver.
// Scans DIGITS common-anode digits from one active-low segment bus, with
// per-digit blanking, leading-zero suppression, a dark dead cycle at the start
// of every digit slot and optional frame-synchronous (tear-free) loading.
module hex_scan_display #(
   parameter int DIGITS    = 4,
   parameter int SCAN_DIV  = 50000,
   parameter bit SYNC_LOAD = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     blank_mask,
   input  logic                  lz_suppress,
   input  logic                  on,
   output logic [6:0]            seg_out,
   output logic [DIGITS-1:0]     an_out,
   output logic                  frame_start,
   output logic                  pending
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

   // Scan position
   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          slot_end;
   logic          wrap;

   // Display shadow and pending buffer
   logic [4*DIGITS-1:0] val_sh_q, val_sh_d;
   logic [DIGITS-1:0]   blank_sh_q, blank_sh_d;
   logic [4*DIGITS-1:0] val_pb_q, val_pb_d;
   logic [DIGITS-1:0]   blank_pb_q, blank_pb_d;
   logic                pend_q, pend_d;

   // Output register
   logic [6:0]        seg_q;
   logic [DIGITS-1:0] an_q;
   logic              frame_start_q;

   // Per-digit decode helpers
   logic [3:0]        digit     [DIGITS];
   logic [DIGITS-1:0] zero_from;   // digits DIGITS-1 down to i are all zero
   logic [DIGITS-1:0] dark;
   logic [DIGITS-1:0] an_sel;

   assign slot_end = (cnt_q == CNT_LAST);
   assign wrap     = slot_end && (idx_q == IDX_LAST);

   // Active-low gfedcba pattern for one hex nibble
   function automatic logic [6:0] seg7(input logic [3:0] h);
      case (h)
         4'h0:    seg7 = 7'b1000000;
         4'h1:    seg7 = 7'b1111001;
         4'h2:    seg7 = 7'b0100100;
         4'h3:    seg7 = 7'b0110000;
         4'h4:    seg7 = 7'b0011001;
         4'h5:    seg7 = 7'b0010010;
         4'h6:    seg7 = 7'b0000010;
         4'h7:    seg7 = 7'b1111000;
         4'h8:    seg7 = 7'b0000000;
         4'h9:    seg7 = 7'b0010000;
         4'hA:    seg7 = 7'b0001000;
         4'hB:    seg7 = 7'b0000011;
         4'hC:    seg7 = 7'b1000110;
         4'hD:    seg7 = 7'b0100001;
         4'hE:    seg7 = 7'b0000110;
         default: seg7 = 7'b0001110;
      endcase
   endfunction

   // Prescaler and digit index advance
   always_comb begin
      cnt_d = slot_end ? '0 : cnt_q + 1'b1;
      idx_d = idx_q;
      if (slot_end) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
   end

   // Load path: direct shadow write, or buffered until the frame wrap.
   // A load on the wrap edge itself goes straight to the shadow and drops
   // whatever was pending.
   always_comb begin
      val_sh_d   = val_sh_q;
      blank_sh_d = blank_sh_q;
      val_pb_d   = val_pb_q;
      blank_pb_d = blank_pb_q;
      pend_d     = pend_q;
      if (!SYNC_LOAD) begin
         if (load) begin
            val_sh_d   = value;
            blank_sh_d = blank_mask;
         end
      end else if (load && wrap) begin
         val_sh_d   = value;
         blank_sh_d = blank_mask;
         pend_d     = 1'b0;
      end else if (load) begin
         val_pb_d   = value;
         blank_pb_d = blank_mask;
         pend_d     = 1'b1;
      end else if (wrap && pend_q) begin
         val_sh_d   = val_pb_q;
         blank_sh_d = blank_pb_q;
         pend_d     = 1'b0;
      end
   end

   // Per-digit value, zero-run, dark flag and anode select
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign digit[gi] = val_sh_q[4*gi +: 4];
      if (gi == DIGITS - 1) begin : g_top
         assign zero_from[gi] = (digit[gi] == 4'h0);
      end else begin : g_lower
         assign zero_from[gi] = zero_from[gi+1] && (digit[gi] == 4'h0);
      end
      if (gi == 0) begin : g_lsd
         // The rightmost digit always shows, so a zero value reads "0".
         assign dark[gi] = blank_sh_q[gi];
      end else begin : g_upper
         assign dark[gi] = blank_sh_q[gi] || (lz_suppress && zero_from[gi]);
      end
      assign an_sel[gi] = (idx_q != IW'(gi));
   end

   // Scan and load state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         idx_q      <= '0;
         val_sh_q   <= '0;
         blank_sh_q <= '0;
         val_pb_q   <= '0;
         blank_pb_q <= '0;
         pend_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         val_sh_q   <= val_sh_d;
         blank_sh_q <= blank_sh_d;
         val_pb_q   <= val_pb_d;
         blank_pb_q <= blank_pb_d;
         pend_q     <= pend_d;
      end
   end

   // Output register: first cycle of each slot is dead to avoid ghosting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q         <= 7'h7F;
         an_q          <= '1;
         frame_start_q <= 1'b0;
      end else begin
         frame_start_q <= wrap;
         if (!on || (cnt_q == '0)) begin
            seg_q <= 7'h7F;
            an_q  <= '1;
         end else begin
            an_q  <= an_sel;
            seg_q <= dark[idx_q] ? 7'h7F : seg7(digit[idx_q]);
         end
      end
   end

   assign seg_out     = seg_q;
   assign an_out      = an_q;
   assign frame_start = frame_start_q;
   assign pending     = pend_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// tb_hex_scan_display: directed vectors for hex_scan_display (DIGITS=4,
// SCAN_DIV=4), one instance with immediate loading and one with
// frame-synchronous loading.
module tb_hex_scan_display;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        load0 = 1'b0;
   logic        load1 = 1'b0;
   logic [15:0] value = 16'h0;
   logic [3:0]  blank = 4'h0;
   logic        lz    = 1'b0;
   logic        on    = 1'b1;
   logic [6:0]  seg0, seg1;
   logic [3:0]  an0, an1;
   logic        fs0, fs1, pend0, pend1;

   int k;              // posedges since reset release
   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [15:0]     value;
      logic [3:0]      blank;
      logic            lz;
      logic            on;
      logic [3:0][6:0] seg;   // expected pattern per digit, [3] first in literal
   } vec_t;

   vec_t vecs [11];

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) k <= 0;
      else        k <= k + 1;
   end

   hex_scan_display #(.DIGITS(4), .SCAN_DIV(4), .SYNC_LOAD(1'b0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .load(load0), .value(value), .blank_mask(blank),
      .lz_suppress(lz), .on(on), .seg_out(seg0), .an_out(an0),
      .frame_start(fs0), .pending(pend0)
   );

   hex_scan_display #(.DIGITS(4), .SCAN_DIV(4), .SYNC_LOAD(1'b1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .load(load1), .value(value), .blank_mask(blank),
      .lz_suppress(lz), .on(on), .seg_out(seg1), .an_out(an1),
      .frame_start(fs1), .pending(pend1)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s k=%0d actual=%h required=%h", name, k, act, exp);
      end
   endtask

   // Expected seg/anode at the current sample given per-digit patterns
   task automatic exp_slot(input int kk, input logic [3:0][6:0] segs, input logic on_,
                           output logic [6:0] es, output logic [3:0] ea);
      int c = (kk - 1) % 4;
      int d = ((kk - 1) / 4) % 4;
      if (c == 0 || !on_) begin
         es = 7'h7F;
         ea = 4'hF;
      end else begin
         es = segs[d];
         ea = ~(4'b0001 << d);
      end
   endtask

   task automatic wait_phase(input int p);
      for (int i = 0; i < 40 && (k % 16) != p; i++) @(negedge clk);
      chk("wait_phase", 16'(k % 16), 16'(p));
   endtask

   // Check the sync-load instance: all four digits show old_c until the
   // shadow swaps at edge wk, new_c afterwards; pending high before wk.
   task automatic run_dut1(input logic [6:0] old_c, input logic [6:0] new_c,
                           input int wk, input int n);
      logic [6:0] es;
      logic [3:0] ea;
      logic [6:0] code;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         code = (k > wk) ? new_c : old_c;
         exp_slot(k, {code, code, code, code}, 1'b1, es, ea);
         chk("sync_seg", {9'b0, seg1}, {9'b0, es});
         chk("sync_an", {12'b0, an1}, {12'b0, ea});
         chk("sync_pending", {15'b0, pend1}, {15'b0, (k < wk)});
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout k=%0d", k);
      $fatal(1, "timeout");
   end

   initial begin
      logic [6:0] es;
      logic [3:0] ea;
      int wk;

      //                value     blank lz    on    d3          d2          d1          d0
      vecs[0]  = '{16'h1234, 4'h0, 1'b0, 1'b1, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
      vecs[1]  = '{16'h89AF, 4'h0, 1'b0, 1'b1, {7'b0000000, 7'b0010000, 7'b0001000, 7'b0001110}};
      vecs[2]  = '{16'h0050, 4'h0, 1'b1, 1'b1, {7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000}};
      vecs[3]  = '{16'h0000, 4'h0, 1'b1, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}};
      vecs[4]  = '{16'h1111, 4'h5, 1'b0, 1'b1, {7'b1111001, 7'b1111111, 7'b1111001, 7'b1111111}};
      vecs[5]  = '{16'h0000, 4'h0, 1'b0, 1'b1, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}};
      vecs[6]  = '{16'hBCDE, 4'h0, 1'b0, 1'b1, {7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110}};
      vecs[7]  = '{16'h0567, 4'h0, 1'b1, 1'b1, {7'b1111111, 7'b0010010, 7'b0000010, 7'b1111000}};
      vecs[8]  = '{16'h0F00, 4'h4, 1'b1, 1'b1, {7'b1111111, 7'b1111111, 7'b1000000, 7'b1000000}};
      vecs[9]  = '{16'h3000, 4'h8, 1'b1, 1'b1, {7'b1111111, 7'b1000000, 7'b1000000, 7'b1000000}};
      vecs[10] = '{16'h1234, 4'h0, 1'b0, 1'b0, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};

      // Reset state
      #2 rst_n = 1'b0;
      #1;
      chk("rst_seg0", {9'b0, seg0}, 16'h7F);
      chk("rst_an0", {12'b0, an0}, 16'hF);
      chk("rst_fs0", {15'b0, fs0}, 16'h0);
      chk("rst_pend1", {15'b0, pend1}, 16'h0);
      repeat (3) @(negedge clk);
      chk("rst_hold_seg1", {9'b0, seg1}, 16'h7F);
      chk("rst_hold_an1", {12'b0, an1}, 16'hF);
      rst_n = 1'b1;
      @(negedge clk);
      chk("first_dead_an0", {12'b0, an0}, 16'hF);
      @(negedge clk);
      chk("first_lit_seg0", {9'b0, seg0}, {9'b0, 7'b1000000});
      chk("first_lit_an0", {12'b0, an0}, 16'hE);

      // Table-driven frames on the immediate-load instance
      for (int v = 0; v < 11; v++) begin
         value = vecs[v].value;
         blank = vecs[v].blank;
         lz    = vecs[v].lz;
         on    = vecs[v].on;
         load0 = 1'b1;
         @(negedge clk);
         load0 = 1'b0;
         for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            exp_slot(k, vecs[v].seg, vecs[v].on, es, ea);
            chk($sformatf("v%0d_seg", v), {9'b0, seg0}, {9'b0, es});
            chk($sformatf("v%0d_an", v), {12'b0, an0}, {12'b0, ea});
            chk($sformatf("v%0d_fs", v), {15'b0, fs0}, {15'b0, ((k % 16) == 0)});
         end
         chk($sformatf("v%0d_pend0", v), {15'b0, pend0}, 16'h0);
      end

      // Sync load: mid-frame load, then a second load wins at the wrap
      lz = 1'b0; blank = 4'h0; on = 1'b1;
      repeat (4) @(negedge clk);
      wait_phase(3);
      value = 16'hAAAA; load1 = 1'b1;
      @(negedge clk);
      load1 = 1'b0;
      chk("pend_after_load", {15'b0, pend1}, 16'h1);
      wait_phase(8);
      value = 16'h7777; load1 = 1'b1;
      @(negedge clk);
      load1 = 1'b0;
      wk = (k / 16 + 1) * 16;
      run_dut1(7'b1000000, 7'b1111000, wk, wk + 8 - k);

      // Sync load: pending 3333 discarded by a load on the wrap edge
      wait_phase(10);
      value = 16'h3333; load1 = 1'b1;
      @(negedge clk);
      load1 = 1'b0;
      chk("pend_3333", {15'b0, pend1}, 16'h1);
      wait_phase(15);
      value = 16'h5555; load1 = 1'b1;
      @(negedge clk);
      load1 = 1'b0;
      wk = k;
      chk("pend_coincident", {15'b0, pend1}, 16'h0);
      run_dut1(7'b1111000, 7'b0010010, wk, 18);

      // Reset in digit 2 with a load pending
      value = 16'h9999;
      wait_phase(6);
      load1 = 1'b1;
      @(negedge clk);
      load1 = 1'b0;
      chk("pend_9999", {15'b0, pend1}, 16'h1);
      wait_phase(10);
      rst_n = 1'b0;
      #1;
      chk("midrst_seg1", {9'b0, seg1}, 16'h7F);
      chk("midrst_an1", {12'b0, an1}, 16'hF);
      chk("midrst_pend1", {15'b0, pend1}, 16'h0);
      chk("midrst_seg0", {9'b0, seg0}, 16'h7F);
      chk("midrst_an0", {12'b0, an0}, 16'hF);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_dead_an0", {12'b0, an0}, 16'hF);
      chk("post_rst_dead_an1", {12'b0, an1}, 16'hF);
      @(negedge clk);
      chk("post_rst_seg0", {9'b0, seg0}, {9'b0, 7'b1000000});
      chk("post_rst_an0", {12'b0, an0}, 16'hE);
      run_dut1(7'b1000000, 7'b1000000, 0, 20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
